mem_stage: RTL

//   Memory-access pipeline stage; sits directly after EX, feeds WB. Latches the EX->MEM bus and the
//   EX load-type sideband, and waits for a variable-latency data-SRAM read response.

---
 rtl/mem_stage.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage that waits on a variable-latency data-SRAM read, then extends and forwards the result
module mem_stage #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [2:0]              ex_ld_op,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_bus,
  output logic                    stallreq_for_mem
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
  logic [2:0]  ld_op_q, ld_op_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc, ex_result, raw, load_data, result;
  logic [3:0]  ram_wen;
  logic [4:0]  waddr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        ram_en, sel_rf_res, rf_we, is_load, we_eff;
  logic        unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};
  assign pc         = bus_q[75:44];
  assign ram_en     = bus_q[43];
  assign ram_wen    = bus_q[42:39];
  assign sel_rf_res = bus_q[38];
  assign rf_we      = bus_q[37];
  assign waddr      = bus_q[36:32];
  assign ex_result  = bus_q[31:0];
  assign is_load    = ram_en & (ram_wen == 4'b0);
  // Pipeline register: capture when MEM runs, bubble when only MEM is held, otherwise hold
  always_comb begin
    bus_d   = !stall[3] ? ex_to_mem_bus : (!stall[4] ? '0 : bus_q);
    ld_op_d = !stall[3] ? ex_ld_op : (!stall[4] ? 3'b0 : ld_op_q);
  end
  // Load-response tracker: a response arriving while MEM is frozen is parked in buf until MEM moves on
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (state_q == DONE) state_d = stall[3] ? DONE : IDLE;
    else if (is_load & data_sram_rvalid) begin
      state_d = stall[3] ? DONE : IDLE;
      buf_d   = stall[3] ? data_sram_rdata : buf_q;
    end else if (is_load) state_d = WAIT;
  end
  // Extension and writeback selection; the response cycle itself releases the stall
  always_comb begin
    stallreq_for_mem = is_load & (state_q != DONE) & !data_sram_rvalid;
    raw       = (state_q == DONE) ? buf_q : data_sram_rdata;
    byte_v    = 8'(raw >> {ex_result[1:0], 3'b0});
    half_v    = 16'(raw >> {ex_result[1], 4'b0});
    load_data = (ld_op_q == 3'b001) ? {{24{byte_v[7]}}, byte_v} :
                (ld_op_q == 3'b010) ? {24'b0, byte_v} :
                (ld_op_q == 3'b011) ? {{16{half_v[15]}}, half_v} :
                (ld_op_q == 3'b100) ? {16'b0, half_v} : raw;
    result    = sel_rf_res ? load_data : ex_result;
    we_eff    = rf_we & !stallreq_for_mem;
    mem_to_wb_bus = {pc, we_eff, waddr, result};
    mem_to_id_bus = {we_eff, waddr, result};
  end
  // State update with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q   <= '0;
      ld_op_q <= '0;
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      bus_q   <= bus_d;
      ld_op_q <= ld_op_d;
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end
endmodule
